// File: rtl/s2p_pkg.sv
// Shared types for the serial-to-parallel receiver.
// The default width matches the parallel-to-serial shifter.
package s2p_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } s2p_state_t;

  localparam int S2P_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_to_parallel_rx_if.sv
// Serial input, word output and status bundle.
// The master side drives bits; the slave is the receiver.
interface serial_to_parallel_rx_if
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH_DEFAULT
) ();

  logic             sIn;
  logic             sEn;
  logic             start;
  logic             ready;
  logic             clrErr;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             busy;
  logic             overrun;
  logic             frameErr;

  modport master (
    output sIn, sEn, start, ready, clrErr,
    input  data, valid, busy, overrun, frameErr
  );

  modport slave (
    input  sIn, sEn, start, ready, clrErr,
    output data, valid, busy, overrun, frameErr
  );

endinterface

// File: rtl/s2p_hold_reg.sv
// Output holding register with valid/ready handshake.
// o_full is high when a load this cycle would be dropped.
module s2p_hold_reg
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH_DEFAULT
) (
  input  logic             Clock,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  assign o_full  = r_valid && !i_ready;
  assign o_data  = r_data;
  assign o_valid = r_valid;

  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load && !o_full) begin
      r_data  <= i_word;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_to_parallel_rx.sv
// MSB-first serial receiver: start-framed words,
// held behind valid/ready, with sticky error flags.
module serial_to_parallel_rx
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_WIDTH_DEFAULT
) (
  input  logic                    Clock,
  input  logic                    rst,
  serial_to_parallel_rx_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  s2p_state_t       r_state;
  s2p_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_word;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_done;
  logic             w_ferr_set;
  logic             w_ovr_set;
  logic             w_full;
  logic             r_overrun;
  logic             r_frameErr;

  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    w_ferr_set  = 1'b0;
    w_word      = {r_shreg[WIDTH-2:0], bus.sIn};
    unique case (r_state)
      IDLE: begin
        if (bus.sEn && bus.start) begin
          w_state_nxt = SHIFT;
          w_shreg_nxt = {{(WIDTH-1){1'b0}}, bus.sIn};
          w_cnt_nxt   = CW'(1);
        end
      end
      SHIFT: begin
        if (bus.sEn && bus.start) begin
          // restart: this bit is the MSB of a new word
          w_ferr_set  = 1'b1;
          w_shreg_nxt = {{(WIDTH-1){1'b0}}, bus.sIn};
          w_cnt_nxt   = CW'(1);
        end else if (bus.sEn) begin
          w_shreg_nxt = w_word;
          if (r_cnt == CW'(WIDTH - 1)) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (r_state == SHIFT);
    bus.overrun  = r_overrun;
    bus.frameErr = r_frameErr;
    w_ovr_set    = w_done && w_full;
  end

  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_overrun  <= (r_overrun && !bus.clrErr) || w_ovr_set;
      r_frameErr <= (r_frameErr && !bus.clrErr) || w_ferr_set;
    end
  end

  s2p_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .Clock   (Clock),
    .rst     (rst),
    .i_load  (w_done),
    .i_word  (w_word),
    .i_ready (bus.ready),
    .o_data  (bus.data),
    .o_valid (bus.valid),
    .o_full  (w_full)
  );

endmodule
